fifo_frame_scheduler: RTL
=========================

Name: fifo_frame_scheduler

Overview:
- Round-robin scheduler that drains NCH single-clock receive FIFOs into one framed output word stream. Each FIFO exposes usedw/empty/rdreq/q, and q is registered one cycle after rdreq.
- A channel is served only when it holds at least FRAME_LEN words. The block then emits one header word followed by exactly FRAME_LEN payload words.
- Sits between the per-receiver sample FIFOs and the Ethernet packet assembler, and is the only reader of those FIFOs.

Parameters:
- NCH, 2, number of source FIFOs (1..4).
- WD, 16, word width of FIFO data and output stream (must be >= 8).
- DP, 11, width of each FIFO usedw.
- FRAME_LEN, 238, payload words per frame (1 .. 2^DP-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  high permits new frames to start; low lets the current frame complete and then holds IDLE.
- fifo_usedw  in  NCH*DP  per-channel fill level; channel i is bits [i*DP +: DP].
- fifo_q  in  NCH*WD  per-channel read data, valid the cycle after that channel's rdreq.
- fifo_rdreq  out  NCH  per-channel read strobe; at most one bit set per cycle.
- out_data  out  WD  output word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_first  out  1  qualifies the header word.
- out_last  out  1  qualifies the final payload word.
- busy  out  1  high from grant until the last payload word has been pushed into the output buffer.
- cur_ch  out  2  index of the granted or last-granted channel.

Behaviour:
- Reset (async assert, release on a clk edge): state IDLE, fifo_rdreq=0, out_valid=0, out_first=0, out_last=0, out_data=0, busy=0, cur_ch=0, rr_ptr=0, seq=0, buffer empty, issued=0, inflight=0.
- Output buffer: 2-entry FIFO carrying {first,last,data}; out_* reflect the head entry.
  - pop = out_valid & out_ready.
  - space = 2 - occupancy - inflight + pop.
  - out_data and out_valid must hold stable while out_valid & !out_ready.
- Eligible(i): fifo_usedw[i] >= FRAME_LEN.
- IDLE:
  - Condition: enable=1, some channel eligible, space >= 1.
  - Grant the first eligible channel searching rr_ptr, rr_ptr+1, ... (modulo NCH).
  - Push header {ch[1:0], seq[WD-3:0]} with first=1. Set cur_ch=ch, busy=1, go to PAY.
- PAY:
  - Assert fifo_rdreq[ch] whenever issued < FRAME_LEN and space >= 1. Count issued and inflight.
  - Each returned fifo_q word is pushed on the following edge; inflight decrements.
  - The word pushed when issued == FRAME_LEN and inflight == 1 is tagged last=1.
  - When issued == FRAME_LEN, go to DONE.
- DONE:
  - Wait for inflight == 0.
  - Then: seq <= seq+1 (wraps modulo 2^(WD-2)), rr_ptr <= (ch+1) mod NCH, busy=0, issued=0, go to IDLE.
- Timing with out_ready held high: header visible the cycle after the grant edge E0; one bubble cycle; payload k visible after edge E0+2+k with no gaps.
  - Next grant is possible on the edge after DONE clears.
- Backpressure: rdreq is throttled by space, so no word is ever lost or duplicated. Deassertion of fifo_rdreq may lag out_ready by zero cycles (space is combinational on pop).
- enable low mid-frame has no effect until the frame ends; the block then stays in IDLE.
- Simultaneous eligibility resolves strictly by rr_ptr. A channel that is continuously eligible waits at most NCH-1 frames.
- Eligibility is re-evaluated only in IDLE. usedw growth during a frame is ignored.
- rst_n low mid-frame aborts immediately with no partial completion. The FIFOs are reset by the same reset domain.
- Never read an empty FIFO. Guaranteed because eligibility ensures FRAME_LEN words and only this block reads.

Test Plan:
- NCH=2, FRAME_LEN=4, ch0 usedw=4 with data 0x0101..0x0104, ready high -> exactly 4 fifo_rdreq[0] pulses; stream 0x0000(first), 0x0101, 0x0102, 0x0103, 0x0104(last); seq then 1; rr_ptr=1.
- Both channels usedw>=12, ready high -> frame order ch0, ch1, ch0, ch1. Headers 0x0000, 0x4001, 0x0002, 0x4003.
- out_ready toggled randomly (50%) over 20 frames -> payload matches a scoreboard, header/last correctly placed, out_data stable while stalled, fifo_rdreq never set with usedw=0.
- enable dropped 2 cycles after grant -> current frame completes with all FRAME_LEN words, then no further rdreq while ch1 usedw=100.
- rst_n pulsed low mid-PAY -> outputs zero asynchronously. After release with eligible ch1 and rr_ptr reset, the next header is 0x4000 (ch1, seq 0) if ch0 is ineligible.
- WD=16, 16384 frames on ch0 -> seq wraps 0x3FFF->0x0000 and header bits [15:14] stay 00.

Source files
------------

// File: rtl/fifo_frame_scheduler.sv
// Round-robin framer: drains NCH rx FIFOs into {header, FRAME_LEN payload} frames; header 1 cycle after grant, payload 2 cycles later.
// FIFO reads are throttled by free space in a 2-entry output buffer, so out_ready stalls never drop or duplicate words.

module sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [CW-1:0] count
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_dat;
            wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module fifo_frame_scheduler #(
   parameter int NCH       = 2,
   parameter int WD        = 16,
   parameter int DP        = 11,
   parameter int FRAME_LEN = 238
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [NCH*DP-1:0] fifo_usedw,
   input  logic [NCH*WD-1:0] fifo_q,
   output logic [NCH-1:0]    fifo_rdreq,
   output logic [WD-1:0]     out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_first,
   output logic              out_last,
   output logic              busy,
   output logic [1:0]        cur_ch
);
   localparam logic [DP-1:0] FL = DP'(FRAME_LEN);

   typedef enum logic [1:0] {IDLE, PAY, DONE} state_t;
   typedef struct packed {
      logic          first;
      logic          last;
      logic [WD-1:0] dat;
   } ent_t;

   state_t        state;
   logic [1:0]    rr_ptr, gnt_ch, nxt_ptr;
   logic [WD-3:0] seq;
   logic [DP-1:0] issued;
   logic          inflight, gnt_vld, hdr_push, push, pop, rd_vld;
   logic [3:0]    elig;
   logic [1:0]    occ;
   logic [2:0]    space;
   ent_t          push_ent, head_ent;

   function automatic logic [1:0] wrap_ch(input logic [2:0] s);
      return (s >= 3'(NCH)) ? 2'(s - 3'(NCH)) : s[1:0];
   endfunction

   // Scan from the far end back toward rr_ptr so the nearest eligible channel wins.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NCH; i++) elig[i] = (fifo_usedw[i*DP +: DP] >= FL);
      gnt_vld = 1'b0;
      gnt_ch  = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (elig[wrap_ch({1'b0, rr_ptr} + 3'(k))]) begin
            gnt_vld = 1'b1;
            gnt_ch  = wrap_ch({1'b0, rr_ptr} + 3'(k));
         end
      end
   end

   assign pop      = out_valid & out_ready;
   assign space    = 3'd2 + {2'b0, pop} - {1'b0, occ} - {2'b0, inflight};
   assign hdr_push = (state == IDLE) && enable && gnt_vld && (space != 3'd0);
   assign rd_vld   = (state == PAY) && (issued < FL) && (space != 3'd0);
   assign push     = hdr_push | inflight;
   assign nxt_ptr  = wrap_ch({1'b0, cur_ch} + 3'd1);

   assign fifo_rdreq = rd_vld ? (NCH'(1) << cur_ch) : '0;

   // Only one read is ever outstanding, so the word returning with issued == FL is the last.
   always_comb begin
      push_ent = '0;
      if (hdr_push) begin
         push_ent.first = 1'b1;
         push_ent.dat   = {gnt_ch, seq};
      end else begin
         push_ent.last = (issued == FL);
         push_ent.dat  = fifo_q[cur_ch*WD +: WD];
      end
   end

   sync_fifo #(.W($bits(ent_t)), .DEPTH(2)) u_obuf (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .head_dat (head_ent),
      .count    (occ)
   );

   assign out_valid = (occ != 2'd0);
   assign out_data  = head_ent.dat;
   assign out_first = out_valid & head_ent.first;
   assign out_last  = out_valid & head_ent.last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         seq      <= '0;
         issued   <= '0;
         inflight <= 1'b0;
         cur_ch   <= '0;
         busy     <= 1'b0;
      end else begin
         inflight <= rd_vld;
         case (state)
            IDLE: if (hdr_push) begin
               cur_ch <= gnt_ch;
               busy   <= 1'b1;
               state  <= PAY;
            end
            PAY: begin
               if (rd_vld) issued <= issued + 1'b1;
               if (issued == FL) state <= DONE;
            end
            DONE: if (!inflight) begin
               seq    <= seq + 1'b1;
               rr_ptr <= nxt_ptr;
               busy   <= 1'b0;
               issued <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
